div_unit: RTL and testbench

//   Iterative signed divider for DIV: quotient -> LO, remainder -> HI (MIPS semantics).

---
 rtl/div_unit_pkg.sv | 18 +
 rtl/div_unit_if.sv | 26 ++
 rtl/div_unit_step.sv | 32 +++
 rtl/div_unit.sv | 139 +++++++++++++
 tb/tb_div_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared types and constants for the iterative divider
// Purpose: FSM state encoding, default datapath width and the divide-by-zero
//          exception cause code consumed by the control unit.
// Ports:   none (package).
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

  // Cause code reported to the control unit when div_zero pulses.
  localparam logic [4:0] EXC_DIV_ZERO = 5'h0f;

endpackage

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/result bundle between control FSM and divider
// Purpose: groups the divider handshake and operand/result signals.
// Signals: start, dividend, divisor (master -> slave);
//          busy, done, div_zero, hi, lo (slave -> master).
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/div_unit_step.sv
// rtl/div_unit_step.sv - one combinational restoring-division step
// Purpose: shifts the next quotient bit into the partial remainder and
//          subtracts the divisor when it fits.
// Ports:   i_rem_in  partial remainder (WIDTH)
//          i_q_msb   next dividend bit shifted in
//          i_dvs     divisor magnitude (WIDTH)
//          o_rem_out updated partial remainder (WIDTH)
//          o_q_bit   quotient bit produced by this step
module div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem_in,
  input  logic             i_q_msb,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem_out,
  output logic             o_q_bit
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;

  // The shifted remainder needs WIDTH+1 bits: with a divisor magnitude of
  // 2^(WIDTH-1) the shift can carry out and must still compare correctly.
  assign w_shift = {i_rem_in, i_q_msb};
  assign o_q_bit = (w_shift >= {1'b0, i_dvs});

  // When the subtraction is taken the true difference is below i_dvs, so the
  // low WIDTH bits of the modular difference are exact.
  assign w_diff    = w_shift[WIDTH-1:0] - i_dvs;
  assign o_rem_out = o_q_bit ? w_diff : w_shift[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative signed divider (quotient -> lo, remainder -> hi)
// Purpose: WIDTH-cycle restoring divide on magnitudes followed by a sign fix
//          cycle; truncates toward zero, remainder takes the dividend's sign.
// Ports:   clk      rising-edge clock
//          reset_n  asynchronous active-low reset
//          bus      div_unit_if.slave: start/dividend/divisor in,
//                   busy/done/div_zero/hi/lo out
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic       clk,
  input logic       reset_n,
  div_unit_if.slave bus
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  div_state_e       r_state;
  div_state_e       w_next_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic             r_sign_q;
  logic             r_sign_r;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_div_zero;
  logic             w_busy;

  logic             w_dvs_zero;
  logic             w_start_ok;
  logic             w_start_zero;
  logic [WIDTH-1:0] w_rem_out;
  logic             w_q_bit;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1),
  // which is representable as unsigned.
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign w_dvs_zero   = (bus.divisor == '0);
  assign w_start_ok   = bus.start && !w_dvs_zero;
  assign w_start_zero = bus.start &&  w_dvs_zero;

  div_unit_step #(.WIDTH(WIDTH)) u_step (
    .i_rem_in  (r_rem),
    .i_q_msb   (r_q[WIDTH-1]),
    .i_dvs     (r_dvs),
    .o_rem_out (w_rem_out),
    .o_q_bit   (w_q_bit)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; start is only looked at in IDLE, so a start while busy
  // is simply dropped.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_start_ok) w_next_state = ST_CALC;
      ST_CALC: if (r_count == LAST) w_next_state = ST_FIX;
      ST_FIX:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      ST_CALC, ST_FIX: w_busy = 1'b1;
      default:         w_busy = 1'b0;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_q        <= '0;
      r_rem      <= '0;
      r_dvs      <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_zero) begin
            r_div_zero <= 1'b1;
          end else if (w_start_ok) begin
            r_q      <= f_mag(bus.dividend);
            r_dvs    <= f_mag(bus.divisor);
            r_sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_sign_r <= bus.dividend[WIDTH-1];
            r_rem    <= '0;
            r_count  <= '0;
          end
        end
        ST_CALC: begin
          r_rem   <= w_rem_out;
          r_q     <= {r_q[WIDTH-2:0], w_q_bit};
          r_count <= r_count + CW'(1);
        end
        ST_FIX: begin
          r_lo   <= r_sign_q ? -r_q   : r_q;
          r_hi   <= r_sign_r ? -r_rem : r_rem;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: unsigned divide of magnitudes, then apply signs.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    exp_t e;
    ma = a[31] ? (32'd0 - a) : a;
    mb = b[31] ? (32'd0 - b) : b;
    q  = ma / mb;
    r  = ma % mb;
    e.lo = (a[31] ^ b[31]) ? (32'd0 - q) : q;
    e.hi = a[31] ? (32'd0 - r) : r;
    return e;
  endfunction

  // Called in the low clock phase; start is sampled on the next rising edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Returns at the falling edge of the done cycle.
  task automatic wait_done(input string tag, input int offset);
    int   edges;
    logic seen;
    exp_t e;
    edges = offset;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else check({tag, "_busy_phase"}, {29'd0, bus.busy, bus.done, bus.div_zero}, 32'h4);
    end
    check({tag, "_done"}, {31'd0, seen}, 32'd1);
    check({tag, "_latency"}, edges, 32'd33);
    check({tag, "_busy_low"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_dz_low"}, {31'd0, bus.div_zero}, 32'd0);
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_lo"}, bus.lo, e.lo);
      check({tag, "_hi"}, bus.hi, e.hi);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    bus.start    = 1'b0;
    bus.dividend = 32'd0;
    bus.divisor  = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_dz", {31'd0, bus.div_zero}, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 100 / 7
    sb.push_back('{lo: 32'd14, hi: 32'd2});
    launch(32'd100, 32'd7);
    wait_done("t1", 0);
    @(negedge clk);
    check("t1_done_pulse", {31'd0, bus.done}, 32'd0);
    check("t1_hold_lo", bus.lo, 32'd14);

    // Signed cases
    sb.push_back('{lo: 32'hffff_fff2, hi: 32'hffff_fffe});
    launch(32'hffff_ff9c, 32'd7);
    wait_done("t2a", 0);
    @(negedge clk);
    sb.push_back('{lo: 32'hffff_fff2, hi: 32'd2});
    launch(32'd100, 32'hffff_fff9);
    wait_done("t2b", 0);
    @(negedge clk);

    // INT_MIN boundaries
    sb.push_back('{lo: 32'h8000_0000, hi: 32'd0});
    launch(32'h8000_0000, 32'hffff_ffff);
    wait_done("t3a", 0);
    @(negedge clk);
    sb.push_back('{lo: 32'h8000_0000, hi: 32'd0});
    launch(32'h8000_0000, 32'd1);
    wait_done("t3b", 0);
    @(negedge clk);

    // Divide by zero: one-cycle pulse, results untouched, never busy
    launch(32'h1234_5678, 32'd0);
    @(negedge clk);
    check("t4_dz_pulse", {29'd0, bus.busy, bus.done, bus.div_zero}, 32'h1);
    check("t4_keep_lo", bus.lo, 32'h8000_0000);
    check("t4_keep_hi", bus.hi, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_quiet", {29'd0, bus.busy, bus.done, bus.div_zero}, 32'h0);
    end
    check("t4_keep_lo2", bus.lo, 32'h8000_0000);

    // start re-pulsed with new operands while busy
    @(negedge clk);
    sb.push_back('{lo: 32'd333, hi: 32'd1});
    launch(32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd55;
    bus.divisor  = 32'd0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("t5_ignored", {29'd0, bus.busy, bus.done, bus.div_zero}, 32'h4);
    bus.dividend = $urandom();
    bus.divisor  = $urandom();
    wait_done("t5", 10);

    // Back-to-back start in the done cycle
    sb.push_back('{lo: 32'hffff_fffd, hi: 32'hffff_ffff});
    launch(32'hffff_fff9, 32'd2);
    wait_done("t5b", 0);

    // Asynchronous reset mid-operation
    @(negedge clk);
    launch(32'd1000, 32'd3);
    repeat (14) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("t6_busy", {31'd0, bus.busy}, 32'd0);
    check("t6_done", {31'd0, bus.done}, 32'd0);
    check("t6_dz", {31'd0, bus.div_zero}, 32'd0);
    check("t6_hi", bus.hi, 32'd0);
    check("t6_lo", bus.lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    sb.push_back('{lo: 32'd4, hi: 32'd1});
    launch(32'd9, 32'd2);
    wait_done("t6b", 0);

    // Random operands against the magnitude model
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ra = $urandom();
      rb = (i == 0) ? 32'h8000_0000 : ($urandom() >> (i * 7));
      if (rb == 32'd0) rb = 32'd5;
      sb.push_back(model(ra, rb));
      launch(ra, rb);
      wait_done("rnd", 0);
    end

    check("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
